// File: rtl/seq_calc_core.sv
// seq_calc_core: sequential responder for the calculator operand interface.
// Takes one operation per in_valid/in_ready handshake and returns the result
// over an out_valid/out_ready port. add/sub/logic/max finish on the accept
// edge; mul (shift-add) and div (restoring) iterate for WIDTH edges.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   a, b [WIDTH-1:0]      unsigned operands
//   oper [2:0]            opcode
//   out_valid / out_ready result handshake
//   out [2*WIDTH-1:0]     result; err flags div-by-zero or disabled div
//
// Build option: define CALC_DIV_EN to compile in the divider. Without it,
// opcode 011 completes in one cycle with out=0, err=1.
module seq_calc_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         oper,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               err
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc, mcand, acc_n;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    sc_res;
  logic             sc_err;
  logic             accept, iter_op;

`ifdef CALC_DIV_EN
  logic             op_div;
  logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [WIDTH:0]   rem_s, diff;

  // One restoring step: shift next dividend bit into the partial remainder,
  // keep the subtraction only if it did not go negative.
  always_comb begin
    rem_s = {rem, quo[WIDTH-1]};
    diff  = rem_s - {1'b0, dvs};
    rem_n = diff[WIDTH] ? rem_s[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  assign iter_op = (oper == 3'b010) || (oper == 3'b011);
`else
  assign iter_op = (oper == 3'b010);
`endif

  assign accept = in_valid && in_ready;
  assign acc_n  = mplier[0] ? acc + mcand : acc;

  // Single-cycle results, zero-extended to RW bits.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (oper)
      3'b000: sc_res = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
      3'b001: sc_res = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
      3'b011: sc_err = 1'b1;  // only reached when the divider is absent
      3'b100: sc_res = {{WIDTH{1'b0}}, a & b};
      3'b101: sc_res = {{WIDTH{1'b0}}, a | b};
      3'b110: sc_res = {{WIDTH{1'b0}}, a ^ b};
      3'b111: sc_res = {{WIDTH{1'b0}}, (a > b) ? a : b};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (accept) state_n = iter_op ? EXEC : DONE;
      EXEC: if (cnt == CW'(1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      out    <= '0;
      err    <= 1'b0;
`ifdef CALC_DIV_EN
      op_div <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          if (iter_op) begin
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
`ifdef CALC_DIV_EN
            op_div <= (oper == 3'b011);
            rem    <= '0;
            quo    <= a;
            dvs    <= b;
`endif
          end else begin
            out <= sc_res;
            err <= sc_err;
          end
        end
        EXEC: begin
          cnt    <= cnt - CW'(1);
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`ifdef CALC_DIV_EN
          rem    <= rem_n;
          quo    <= quo_n;
          // Last iteration: register the step's combinational result directly.
          if (cnt == CW'(1)) begin
            if (op_div) begin
              out <= (dvs == '0) ? {RW{1'b1}} : {rem_n, quo_n};
              err <= (dvs == '0);
            end else begin
              out <= acc_n;
              err <= 1'b0;
            end
          end
`else
          if (cnt == CW'(1)) begin
            out <= acc_n;
            err <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calc_core.sv
// Scoreboard bench for seq_calc_core (WIDTH=4). The driver pushes expected
// {out, err, latency} at each accept; a negedge monitor pops and compares on
// every result handshake. Handles both CALC_DIV_EN builds.
module tb_seq_calc_core;
  localparam int W = 4;

  logic         clk = 0, rst = 1;
  logic         in_valid = 0, in_ready;
  logic [W-1:0] a = 0, b = 0;
  logic [2:0]   oper = 0;
  logic         out_valid, out_ready = 1;
  logic [2*W-1:0] out;
  logic         err;

  seq_calc_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .oper(oper), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] o; logic e; int lat; int acc; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, rise = 0;
  logic ov_q = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare on each result handshake.
  always @(negedge clk) begin
    if (rst) ov_q = 0;
    else begin
      if (out_valid && !ov_q) rise = cyc;
      ov_q = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out", out, e.o);
          chk("err", err, e.e);
          chk("latency", rise - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] op,
                       input logic [7:0] eo, input logic ee, input int lat);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    a = ia; b = ib; oper = op; in_valid = 1;
    e.o = eo; e.e = ee; e.lat = lat; e.acc = cyc + 1;
    q.push_back(e);
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin tick(); n++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  logic [7:0] exp9[8] = '{8'h0C, 8'h06, 8'h1B, 8'h03, 8'h01, 8'h0B, 8'h0A, 8'h09};
  int         lat9[8] = '{1, 1, 5, 5, 1, 1, 1, 1};

  initial begin
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_err", err, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 8; i++) begin
`ifdef CALC_DIV_EN
      issue(4'd9, 4'd3, 3'(i), exp9[i], 1'b0, lat9[i]);
`else
      if (i == 3) issue(4'd9, 4'd3, 3'(i), 8'h00, 1'b1, 1);
      else        issue(4'd9, 4'd3, 3'(i), exp9[i], 1'b0, lat9[i]);
`endif
    end
    drain();

    issue(4'd3, 4'd9, 3'b001, 8'hFA, 1'b0, 1);
    drain();

    issue(4'd15, 4'd15, 3'b010, 8'hE1, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      chk("mul_in_ready_busy", in_ready, 0);
      tick();
    end
    drain();

`ifdef CALC_DIV_EN
    issue(4'd7, 4'd0, 3'b011, 8'hFF, 1'b1, 5);
`else
    issue(4'd7, 4'd0, 3'b011, 8'h00, 1'b1, 1);
`endif
    drain();

    // Backpressure: result must hold and new requests must be ignored.
    out_ready = 0;
    issue(4'd5, 4'd6, 3'b100, 8'h04, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      a = 4'd1; b = 4'd1; oper = 3'b000; in_valid = 1;
      tick();
      chk("bp_out", out, 8'h04);
      chk("bp_err", err, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    drain();

    // Reset during mul EXEC aborts the operation with no result.
    issue(4'd15, 4'd15, 3'b010, 8'hE1, 1'b0, 5);
    tick();
    rst = 1;
    void'(q.pop_back());
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    tick();
    rst = 0;
    tick();
    issue(4'd2, 4'd2, 3'b000, 8'h04, 1'b0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
